// File: rtl/mul_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
//   state | meaning
//   IDLE  | waiting for START, PRODUCT holds the last result
//   RUN   | one shift-add step per cycle, BUSY high
//   FIN   | single cycle, DONE high, PRODUCT valid
package mul_pkg;

    localparam int MUL_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_sign_adj.sv
// Conditional two's-complement negation of an N-bit value.
// Used for operand magnitude extraction and for result sign correction.
// The most-negative input maps onto itself, which read as unsigned is
// exactly its magnitude, so no extra width is needed.
module mul_sign_adj #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_val,
    input  logic         i_neg,
    output logic [N-1:0] o_val
);

    // Negate when requested, pass through otherwise
    always_comb begin
        o_val = i_val;
        if (i_neg) begin
            o_val = ~i_val + N'(1);
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH bits.
// Fixed latency of WIDTH RUN cycles plus one FIN cycle, no early exit.
// Optional feature macro: MUL_SIGNED_EN adds the SIGNED_OP port and the
// sign-magnitude wrapper around the unsigned core.
//
//   state | meaning
//   IDLE  | waiting for START
//   RUN   | shift-add steps, counter runs WIDTH-1 down to 0
//   FIN   | DONE pulse; START here chains straight into RUN
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH       = MUL_WIDTH_DEF,
    parameter int HOLD_RESULT = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
`ifdef MUL_SIGNED_EN
    input  logic                 SIGNED_OP,
`endif
    output logic                 BUSY,
    output logic                 DONE,
    output logic [2*WIDTH-1:0]   PRODUCT
);

    localparam int CW = $clog2(WIDTH);

    mul_state_t           r_state;
    mul_state_t           w_next;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_capture;
    logic                 w_last;

    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_result;

    // A new operation is only accepted outside RUN
    assign w_capture = START && ((r_state == IDLE) || (r_state == FIN));
    assign w_last    = (r_state == RUN) && (r_cnt == '0);

`ifdef MUL_SIGNED_EN
    logic w_neg_a;
    logic w_neg_b;
    logic r_neg;

    assign w_neg_a = SIGNED_OP & A[WIDTH-1];
    assign w_neg_b = SIGNED_OP & B[WIDTH-1];

    mul_sign_adj #(.N(WIDTH)) u_adj_a (
        .i_val (A),
        .i_neg (w_neg_a),
        .o_val (w_mag_a)
    );

    mul_sign_adj #(.N(WIDTH)) u_adj_b (
        .i_val (B),
        .i_neg (w_neg_b),
        .o_val (w_mag_b)
    );

    mul_sign_adj #(.N(2*WIDTH)) u_adj_p (
        .i_val (w_acc_next),
        .i_neg (r_neg),
        .o_val (w_result)
    );

    // Result sign is fixed at capture so later operand changes cannot leak in
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_neg <= 1'b0;
        end else if (w_capture) begin
            r_neg <= w_neg_a ^ w_neg_b;
        end
    end
`else
    assign w_mag_a  = A;
    assign w_mag_b  = B;
    assign w_result = w_acc_next;
`endif

    // One shift-add step: add multiplicand into the high half when the
    // current multiplier bit is set, then shift the whole accumulator right
    assign w_addend   = r_lo[0] ? r_mcand : '0;
    assign w_sum      = {1'b0, r_hi} + {1'b0, w_addend};
    assign w_acc_next = {w_sum, r_lo[WIDTH-1:1]};

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and status outputs
    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (START) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (r_cnt == '0) begin
                    w_next = FIN;
                end
            end
            FIN: begin
                w_done = 1'b1;
                w_next = START ? RUN : IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operand capture, iteration counter and accumulator
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt   <= '0;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (w_capture) begin
            r_cnt   <= CW'(WIDTH - 1);
            r_mcand <= w_mag_a;
            r_hi    <= '0;
            r_lo    <= w_mag_b;
        end else if (r_state == RUN) begin
            r_hi <= w_sum[WIDTH:1];
            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // Result register: loaded on entry to FIN, optionally cleared at capture
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_product <= '0;
        end else if (w_last) begin
            r_product <= w_result;
        end else if (w_capture && (HOLD_RESULT == 0)) begin
            r_product <= '0;
        end
    end

    assign BUSY    = w_busy;
    assign DONE    = w_done;
    assign PRODUCT = r_product;

endmodule
